onewire_slave_model: RTL and testbench
======================================

ONEWIRE_SLAVE_MODEL -- requirements
Module: onewire_slave_model

Interface
REQ-001 The block SHALL provide the following parameters, one per line: name, default, meaning.
- CLK_PER_US, 12, clock cycles per microsecond.
- RESET_MIN_US, 480, minimum bus-low time recognised as a reset pulse.
- PRES_WAIT_US, 30, delay from reset release to start of presence pulse.
- PRES_US, 120, presence pulse length.
- SAMPLE_US, 30, write-slot sample point after falling edge.
- READ_HOLD_US, 30, pull-low length for a read-slot 0.
- CONV_US, 750000, Convert T busy time.
- SCRATCH_TAIL, 48'h1F_FF_0C_10_4B_46, scratchpad bytes 2..7, byte 2 in LSBs.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, all logic on rising edge.
- rst, in, 1, synchronous, active-high reset.
- I_ONE_WIRE, in, 1, sensed bus level, asynchronous to clk.
- O_ONE_WIRE_PULL, out, 1, 1 = drive bus low, 0 = release.
- I_TEMP, in, 16, temperature value captured at conversion end.
- O_CMD, out, 8, last received byte.
- O_CMD_VALID, out, 1, one-cycle pulse when O_CMD updates.
- O_BUSY, out, 1, conversion in progress.

Function
REQ-003 I_ONE_WIRE SHALL pass through a 2-flop synchroniser; the falling edge is detected on the synchronised signal, 2-3 cycles after the pin changes.
REQ-004 Time counters SHALL be in clock cycles (X_US*CLK_PER_US), wide enough for CONV_US*CLK_PER_US without wrap.
REQ-005 States SHALL be IDLE, PRES_WAIT, PRES, ROM_CMD, FUNC_CMD, READ_TX, HALT.
REQ-006 A low-time counter SHALL run in every state; a rising edge after a low of at least RESET_MIN_US SHALL abort any state, clear the bit/byte counters and enter PRES_WAIT; a shorter low SHALL not cause a reset.
REQ-007 PRES_WAIT SHALL last PRES_WAIT_US; PRES SHALL assert O_ONE_WIRE_PULL for exactly PRES_US, then enter ROM_CMD.
REQ-008 In ROM_CMD and FUNC_CMD, each falling edge SHALL start a slot; the bus SHALL be sampled SAMPLE_US later and shifted in LSB first; after 8 bits O_CMD is loaded and O_CMD_VALID pulses for one cycle.
REQ-009 ROM_CMD: 0xCC SHALL go to FUNC_CMD; any other byte SHALL go to HALT.
REQ-010 FUNC_CMD: 0x44 SHALL set O_BUSY for CONV_US and return to FUNC_CMD; 0xBE SHALL go to READ_TX at byte 0; any other byte SHALL go to HALT.
REQ-011 When busy ends, I_TEMP SHALL be latched into scratchpad bytes 0 (LSB) and 1, and O_BUSY SHALL clear in the same cycle.
REQ-012 While O_BUSY=1 in FUNC_CMD, a read slot SHALL answer 0 by pulling low for READ_HOLD_US; after the conversion it SHALL answer 1 by not pulling.
REQ-013 READ_TX SHALL send 9 bytes LSB first: the latched temperature (2 bytes), SCRATCH_TAIL (6 bytes), and a Dallas CRC8 (x^8+x^5+x^4+1, init 0) over bytes 0..7; a 0 bit pulls for READ_HOLD_US from the falling edge, a 1 bit does not pull.
REQ-014 After 72 bits, READ_TX SHALL enter HALT; in HALT, pulls SHALL stay released until a reset pulse.
REQ-015 A reset pulse during a conversion SHALL NOT cancel the conversion timer.
REQ-016 O_ONE_WIRE_PULL SHALL be registered and glitch-free.

Reset
REQ-017 When rst=1: state=IDLE, O_ONE_WIRE_PULL=0, O_CMD=0, O_CMD_VALID=0, O_BUSY=0, latched temperature=16'h0550, and all counters and synchronisers reset to idle-high. rst takes effect on the next clock edge, including mid-presence or mid-slot.

Verification (CLK_PER_US=1, CONV_US=1000)
REQ-018 Bus low 500 us, then released -> O_ONE_WIRE_PULL rises 30 us (±3 cycles) after release and stays high for 120 us.
REQ-019 Bus low 200 us -> no presence pulse; state unchanged.
REQ-020 Reset, write 0xCC then 0x44 -> O_CMD_VALID pulses with 0xCC then 0x44; O_BUSY=1 for 1000 cycles; read slots return 0 during the conversion and 1 after it.
REQ-021 I_TEMP=16'h0191, conversion done, reset, write 0xCC then 0xBE, then 72 read slots -> bytes 91 01 46 4B 10 0C FF 1F followed by the CRC8 of those bytes, which the bench checks with a reference model.
REQ-022 Reset, write 0x33 -> HALT; 16 read slots -> O_ONE_WIRE_PULL stays 0; next 500 us reset -> presence returns.
REQ-023 rst=1 during PRES -> O_ONE_WIRE_PULL=0 on the next edge, O_BUSY=0, and no presence follows.

Source files
------------

// File: rtl/onewire_slave_model_if.sv
// Bus-side signal bundle for the 1-Wire temperature-sensor slave model.
// The slave modport is the sensor; the master modport is whatever owns the wire and reads results.
interface onewire_slave_model_if;
  logic        I_ONE_WIRE;
  logic        O_ONE_WIRE_PULL;
  logic [15:0] I_TEMP;
  logic [7:0]  O_CMD;
  logic        O_CMD_VALID;
  logic        O_BUSY;

  modport slave (
    input  I_ONE_WIRE, I_TEMP,
    output O_ONE_WIRE_PULL, O_CMD, O_CMD_VALID, O_BUSY
  );

  modport master (
    output I_ONE_WIRE, I_TEMP,
    input  O_ONE_WIRE_PULL, O_CMD, O_CMD_VALID, O_BUSY
  );
endinterface

// File: rtl/onewire_slave_model.sv
// Behavioural 1-Wire temperature-sensor slave: reset/presence, Skip ROM, Convert T,
// Read Scratchpad with Dallas CRC8. All bus timing is derived from CLK_PER_US.
module onewire_slave_model #(
  parameter int unsigned CLK_PER_US   = 12,
  parameter int unsigned RESET_MIN_US = 480,
  parameter int unsigned PRES_WAIT_US = 30,
  parameter int unsigned PRES_US      = 120,
  parameter int unsigned SAMPLE_US    = 30,
  parameter int unsigned READ_HOLD_US = 30,
  parameter int unsigned CONV_US      = 750000,
  parameter logic [47:0] SCRATCH_TAIL = 48'h1F_FF_0C_10_4B_46
) (
  input  logic clk,
  input  logic rst,
  onewire_slave_model_if.slave ow
);

  localparam int unsigned RST_CYC    = RESET_MIN_US * CLK_PER_US;
  localparam int unsigned PW_FULL    = PRES_WAIT_US * CLK_PER_US;
  // Synchroniser plus edge detect already eat ~2 cycles of the wait after release.
  localparam int unsigned PW_CYC     = (PW_FULL > 3) ? PW_FULL - 2 : 1;
  localparam int unsigned PRES_CYC   = PRES_US * CLK_PER_US;
  localparam int unsigned SAMPLE_CYC = SAMPLE_US * CLK_PER_US;
  localparam int unsigned HOLD_CYC   = READ_HOLD_US * CLK_PER_US;
  localparam int unsigned SLOT_END   = (SAMPLE_CYC > HOLD_CYC) ? SAMPLE_CYC : HOLD_CYC;
  localparam int unsigned CONV_CYC   = CONV_US * CLK_PER_US;
  localparam int unsigned SHORT_MAX  = (PW_CYC > PRES_CYC) ?
                                       ((PW_CYC > SLOT_END) ? PW_CYC : SLOT_END) :
                                       ((PRES_CYC > SLOT_END) ? PRES_CYC : SLOT_END);
  localparam int unsigned SHORT_W    = $clog2(SHORT_MAX + 1);
  localparam int unsigned LOW_W      = $clog2(RST_CYC + 1);
  localparam int unsigned CONV_W     = $clog2(CONV_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, PRES_WAIT, PRES, ROM_CMD, FUNC_CMD, READ_TX, HALT
  } state_t;

  state_t             r_state, w_state_next;
  logic               r_sync1, r_sync2, r_prev;
  logic [LOW_W-1:0]   r_low_cnt;
  logic [SHORT_W-1:0] r_tmr;
  logic               r_slot_act, r_drive_low, r_poll;
  logic [SHORT_W-1:0] r_slot_cnt;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic [6:0]         r_tx_idx;
  logic [15:0]        r_temp;
  logic [CONV_W-1:0]  r_conv_cnt;
  logic               r_busy, r_pull, r_cmd_valid;
  logic [7:0]         r_cmd;

  logic        w_fall, w_rise, w_reset_pulse, w_rx_state, w_slot_start;
  logic        w_sample, w_slot_end, w_rx_bit, w_byte_done, w_tx_last, w_conv_start;
  logic [7:0]  w_byte;
  logic [71:0] w_scratch;

  function automatic logic [7:0] f_crc8(input logic [63:0] i_data);
    logic [7:0] c;
    logic       fb;
    c = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      fb = c[0] ^ i_data[i];
      c  = {1'b0, c[7:1]} ^ (fb ? 8'h8C : 8'h00);
    end
    return c;
  endfunction

  assign w_fall        = r_prev & ~r_sync2;
  assign w_rise        = ~r_prev & r_sync2;
  assign w_reset_pulse = w_rise && (r_low_cnt == LOW_W'(RST_CYC));
  assign w_rx_state    = (r_state == ROM_CMD) || (r_state == FUNC_CMD);
  assign w_slot_start  = w_fall && !r_slot_act && (w_rx_state || (r_state == READ_TX));
  assign w_sample      = r_slot_act && (r_slot_cnt == SHORT_W'(SAMPLE_CYC));
  assign w_slot_end    = r_slot_act && (r_slot_cnt == SHORT_W'(SLOT_END));
  // Slots issued while a conversion runs are status polls and never enter the command shifter.
  assign w_rx_bit      = w_sample && w_rx_state && !r_poll;
  assign w_byte        = {r_sync2, r_shift[7:1]};
  assign w_byte_done   = w_rx_bit && (r_bit_cnt == 3'd7);
  assign w_tx_last     = (r_tx_idx == 7'd71);
  assign w_conv_start  = w_byte_done && (r_state == FUNC_CMD) && (w_byte == 8'h44);
  assign w_scratch     = {f_crc8({SCRATCH_TAIL, r_temp}), SCRATCH_TAIL, r_temp};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, HALT: w_state_next = r_state;
      PRES_WAIT:  if (r_tmr == SHORT_W'(PW_CYC - 1)) w_state_next = PRES;
      PRES:       if (r_tmr == SHORT_W'(PRES_CYC - 1)) w_state_next = ROM_CMD;
      ROM_CMD:    if (w_byte_done) w_state_next = (w_byte == 8'hCC) ? FUNC_CMD : HALT;
      FUNC_CMD: begin
        if (w_byte_done) begin
          case (w_byte)
            8'h44:   w_state_next = FUNC_CMD;
            8'hBE:   w_state_next = READ_TX;
            default: w_state_next = HALT;
          endcase
        end
      end
      READ_TX:    if (w_slot_end && w_tx_last) w_state_next = HALT;
      default:    w_state_next = IDLE;
    endcase
    if (w_reset_pulse) w_state_next = PRES_WAIT;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_prev      <= 1'b1;
      r_low_cnt   <= '0;
      r_tmr       <= '0;
      r_slot_act  <= 1'b0;
      r_slot_cnt  <= '0;
      r_drive_low <= 1'b0;
      r_poll      <= 1'b0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_tx_idx    <= '0;
      r_temp      <= 16'h0550;
      r_conv_cnt  <= '0;
      r_busy      <= 1'b0;
      r_pull      <= 1'b0;
      r_cmd       <= '0;
      r_cmd_valid <= 1'b0;
    end else begin
      r_sync1 <= ow.I_ONE_WIRE;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;

      if (r_sync2)                           r_low_cnt <= '0;
      else if (r_low_cnt != LOW_W'(RST_CYC)) r_low_cnt <= r_low_cnt + 1'b1;

      if ((w_state_next != r_state) || w_reset_pulse) r_tmr <= '0;
      else                                            r_tmr <= r_tmr + 1'b1;

      r_cmd_valid <= 1'b0;
      if (w_reset_pulse) begin
        r_slot_act <= 1'b0;
        r_bit_cnt  <= '0;
        r_shift    <= '0;
        r_tx_idx   <= '0;
      end else begin
        if (w_slot_start) begin
          r_slot_act  <= 1'b1;
          r_slot_cnt  <= '0;
          r_poll      <= (r_state == FUNC_CMD) && r_busy;
          r_drive_low <= (r_state == READ_TX) ? ~w_scratch[r_tx_idx]
                                              : ((r_state == FUNC_CMD) && r_busy);
        end else if (r_slot_act) begin
          if (w_slot_end) r_slot_act <= 1'b0;
          r_slot_cnt <= r_slot_cnt + 1'b1;
        end
        if (w_rx_bit) begin
          r_shift   <= w_byte;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (w_byte_done) begin
            r_cmd       <= w_byte;
            r_cmd_valid <= 1'b1;
          end
        end
        if ((r_state == READ_TX) && w_slot_end)                 r_tx_idx <= r_tx_idx + 1'b1;
        if ((w_state_next == READ_TX) && (r_state != READ_TX)) r_tx_idx <= '0;
      end

      // The conversion timer runs independently of bus resets.
      if (r_busy) begin
        if (r_conv_cnt == '0) begin
          r_busy <= 1'b0;
          r_temp <= ow.I_TEMP;
        end else begin
          r_conv_cnt <= r_conv_cnt - 1'b1;
        end
      end else if (w_conv_start && !w_reset_pulse) begin
        r_busy     <= 1'b1;
        r_conv_cnt <= CONV_W'(CONV_CYC - 1);
      end

      r_pull <= (w_state_next == PRES) ||
                ((r_state != HALT) && r_slot_act && r_drive_low &&
                 (r_slot_cnt < SHORT_W'(HOLD_CYC)));
    end
  end

  assign ow.O_ONE_WIRE_PULL = r_pull;
  assign ow.O_CMD           = r_cmd;
  assign ow.O_CMD_VALID     = r_cmd_valid;
  assign ow.O_BUSY          = r_busy;

endmodule

// File: tb/tb_onewire_slave_model.sv
// Scoreboard bench for the 1-Wire slave model: a bus master drives reset, write and read
// slots on a wired-AND line; expected command bytes and read bits are queued and compared.
module tb_onewire_slave_model;
  logic clk = 1'b0;
  logic rst;
  logic r_m_low;
  int   n_cmp = 0;
  int   n_err = 0;
  int   busy_cnt = 0;
  logic [7:0] q_cmd[$];
  logic       q_bit[$];

  onewire_slave_model_if bus();
  assign bus.I_ONE_WIRE = ~(r_m_low | bus.O_ONE_WIRE_PULL);

  always #5 clk = ~clk;

  onewire_slave_model #(.CLK_PER_US(1), .CONV_US(1000)) dut (
    .clk (clk),
    .rst (rst),
    .ow  (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.O_CMD_VALID) begin
      if (q_cmd.size() == 0) chk("cmd_unexpected", 32'(bus.O_CMD), 32'hFFFF_FFFF);
      else                   chk("cmd_byte", 32'(bus.O_CMD), 32'(q_cmd.pop_front()));
    end
    if (bus.O_BUSY) busy_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_reset(input int low);
    @(negedge clk);
    r_m_low = 1'b1;
    repeat (low) @(negedge clk);
    r_m_low = 1'b0;
  endtask

  task automatic wait_pres(input int max, output int dly, output int wid);
    dly = -1;
    wid = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (bus.O_ONE_WIRE_PULL) begin
        dly = i;
        break;
      end
    end
    if (dly >= 0)
      while (bus.O_ONE_WIRE_PULL && wid < 400) begin
        wid++;
        @(negedge clk);
      end
  endtask

  task automatic pres_check(input string tag);
    int d, w;
    bus_reset(500);
    wait_pres(60, d, w);
    chk({tag, "_delay"}, 32'(d >= 27 && d <= 33), 32'd1);
    chk({tag, "_width"}, 32'(w), 32'd120);
    idle(20);
  endtask

  task automatic write_bit(input logic b);
    @(negedge clk);
    r_m_low = 1'b1;
    repeat (b ? 6 : 60) @(negedge clk);
    r_m_low = 1'b0;
    repeat (b ? 64 : 10) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] v);
    q_cmd.push_back(v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask

  task automatic read_bit(input logic e, input string tag);
    logic s;
    q_bit.push_back(e);
    @(negedge clk);
    r_m_low = 1'b1;
    repeat (6) @(negedge clk);
    r_m_low = 1'b0;
    repeat (9) @(negedge clk);
    s = bus.I_ONE_WIRE;
    chk(tag, 32'(s), 32'(q_bit.pop_front()));
    repeat (55) @(negedge clk);
  endtask

  task automatic read_byte(input logic [7:0] e, input string tag);
    for (int i = 0; i < 8; i++) read_bit(e[i], tag);
  endtask

  function automatic logic [7:0] ref_crc(input logic [7:0] bytes[8]);
    logic [7:0] crc, b;
    logic       mix;
    crc = 8'h00;
    for (int k = 0; k < 8; k++) begin
      b = bytes[k];
      for (int j = 0; j < 8; j++) begin
        mix = crc[0] ^ b[0];
        crc = crc >> 1;
        if (mix) crc = crc ^ 8'h8C;
        b = b >> 1;
      end
    end
    return crc;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, w;
    logic [7:0] sp[8];
    logic [7:0] crc;

    rst = 1'b1;
    r_m_low = 1'b0;
    bus.I_TEMP = 16'h0191;
    repeat (3) @(negedge clk);
    chk("rst_pull",  32'(bus.O_ONE_WIRE_PULL), 32'd0);
    chk("rst_cmd",   32'(bus.O_CMD),           32'd0);
    chk("rst_valid", 32'(bus.O_CMD_VALID),     32'd0);
    chk("rst_busy",  32'(bus.O_BUSY),          32'd0);
    rst = 1'b0;
    idle(5);

    bus_reset(200);
    wait_pres(200, d, w);
    chk("short_low_no_pres", 32'(d), 32'hFFFF_FFFF);

    pres_check("pres1");

    busy_cnt = 0;
    write_byte(8'hCC);
    write_byte(8'h44);
    chk("busy_set", 32'(bus.O_BUSY), 32'd1);
    for (int i = 0; i < 3; i++) read_bit(1'b0, "poll_busy");
    for (int i = 0; i < 1200 && bus.O_BUSY; i++) @(negedge clk);
    chk("busy_done", 32'(bus.O_BUSY), 32'd0);
    chk("busy_len", 32'(busy_cnt), 32'd1000);
    for (int i = 0; i < 3; i++) read_bit(1'b1, "poll_done");

    pres_check("pres2");
    write_byte(8'hCC);
    write_byte(8'hBE);
    sp = '{8'h91, 8'h01, 8'h46, 8'h4B, 8'h10, 8'h0C, 8'hFF, 8'h1F};
    crc = ref_crc(sp);
    for (int k = 0; k < 8; k++) read_byte(sp[k], "scratch_byte");
    read_byte(crc, "scratch_crc");
    read_bit(1'b1, "after_tx");
    read_bit(1'b1, "after_tx");

    bus.I_TEMP = 16'h0BEE;
    pres_check("pres3");
    write_byte(8'hCC);
    write_byte(8'h44);
    pres_check("pres_conv");
    chk("busy_survives_reset", 32'(bus.O_BUSY), 32'd1);
    for (int i = 0; i < 1500 && bus.O_BUSY; i++) @(negedge clk);
    chk("busy_done2", 32'(bus.O_BUSY), 32'd0);

    pres_check("pres4");
    write_byte(8'h33);
    for (int i = 0; i < 16; i++) read_bit(1'b1, "halt_read");
    pres_check("pres_after_halt");

    bus_reset(500);
    for (int i = 0; i < 60 && !bus.O_ONE_WIRE_PULL; i++) @(negedge clk);
    chk("pres_started", 32'(bus.O_ONE_WIRE_PULL), 32'd1);
    idle(10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midpres_rst_pull", 32'(bus.O_ONE_WIRE_PULL), 32'd0);
    chk("midpres_rst_busy", 32'(bus.O_BUSY),          32'd0);
    chk("midpres_rst_cmd",  32'(bus.O_CMD),           32'd0);
    rst = 1'b0;
    wait_pres(300, d, w);
    chk("no_pres_after_rst", 32'(d), 32'hFFFF_FFFF);

    pres_check("pres5");
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_byte(8'h50, "temp_rst_lo");
    read_byte(8'h05, "temp_rst_hi");

    idle(10);
    chk("cmd_q_empty", 32'(q_cmd.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
